btn_enable_ctrl: RTL and testbench

- Upstream stage of the LED blink controller. It conditions a raw mechanical push-button (KEY, active-low on board) into a clean, level `enable`.
- `enable` drives the blink controller's `enable` input directly.
- Flow: synchronizes the button, debounces press and release, toggles `enable` once per confirmed press, and emits a one-cycle press strobe.
- Clock is 50 MHz, shared with the blink controller.

---
 rtl/btn_enable_ctrl.sv | 159 +++++++++++++++
 tb/tb_btn_enable_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_enable_ctrl.sv
// ============================================================================
// Module      : btn_enable_ctrl
// Description : Synchronizes and debounces an active-low push-button. Each
//               confirmed press toggles the level output `enable` and emits a
//               one-cycle strobe on `press_pulse`. Define LONG_PRESS_EN to add
//               a long-press strobe that also forces `enable` low.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_enable_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned LONG_CYCLES     = 100_000_000,
    parameter bit          ENABLE_RST      = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic enable,
    output logic press_pulse,
    output logic long_press
);

    localparam int unsigned MAX_CYCLES = (DEBOUNCE_CYCLES > LONG_CYCLES) ?
                                         DEBOUNCE_CYCLES : LONG_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] ST_PRESSED      = 2'd2;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

    logic [1:0]       sync_q;
    logic             btn_s;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             enable_q, enable_d;
    logic             press_pulse_q, press_pulse_d;
    logic             confirm;

    // sync_q[1] is the metastability-filtered sample; idle level is released.
    assign btn_s   = ~sync_q[1];
    assign confirm = (state_q == ST_PRESS_WAIT) && btn_s && (cnt_q == DEB_LAST);

`ifdef LONG_PRESS_EN
    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] LP_DONE = CNT_W'(LONG_CYCLES);

    logic [CNT_W-1:0] lp_cnt_q, lp_cnt_d;
    logic             long_press_q, long_press_d;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q        <= 2'b11;
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            enable_q      <= ENABLE_RST;
            press_pulse_q <= 1'b0;
`ifdef LONG_PRESS_EN
            lp_cnt_q      <= '0;
            long_press_q  <= 1'b0;
`endif
        end else begin
            sync_q        <= {sync_q[0], btn_n};
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            enable_q      <= enable_d;
            press_pulse_q <= press_pulse_d;
`ifdef LONG_PRESS_EN
            lp_cnt_q      <= lp_cnt_d;
            long_press_q  <= long_press_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (btn_s) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!btn_s) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ST_PRESSED;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_PRESSED: begin
                if (!btn_s) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                if (btn_s) begin
                    state_d = ST_PRESSED;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        press_pulse_d = confirm;
        enable_d      = confirm ? ~enable_q : enable_q;
`ifdef LONG_PRESS_EN
        lp_cnt_d      = lp_cnt_q;
        long_press_d  = 1'b0;
        if (state_q == ST_IDLE) begin
            lp_cnt_d = '0;
        end else if (state_q == ST_PRESSED) begin
            // Parking the counter one past the trigger value allows one strobe per press.
            if (lp_cnt_q == LP_LAST) begin
                long_press_d = 1'b1;
                enable_d     = 1'b0;
                lp_cnt_d     = LP_DONE;
            end else if (lp_cnt_q < LP_LAST) begin
                lp_cnt_d = lp_cnt_q + CNT_W'(1);
            end
        end
`endif
    end

    assign enable      = enable_q;
    assign press_pulse = press_pulse_q;
`ifdef LONG_PRESS_EN
    assign long_press  = long_press_q;
`else
    assign long_press  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_btn_enable_ctrl.sv
// ============================================================================
// Module      : tb_btn_enable_ctrl
// Description : Self-checking bench for btn_enable_ctrl (table, directed and
//               random stimulus against a run-length reference model).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_btn_enable_ctrl;

    localparam int D   = 4;
    localparam int L   = 10;
    localparam bit ENR = 1'b0;
`ifdef LONG_PRESS_EN
    localparam bit LP_ON = 1'b1;
`else
    localparam bit LP_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic btn_n;
    logic enable;
    logic press_pulse;
    logic long_press;

    always #5 clk = ~clk;

    btn_enable_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .LONG_CYCLES    (L),
        .ENABLE_RST     (ENR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_n      (btn_n),
        .enable     (enable),
        .press_pulse(press_pulse),
        .long_press (long_press)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int seg_pulses;
    int seg_longs;

    // Reference model: two-stage sample delay, then run lengths of the
    // synchronized level decide when a press or release becomes confirmed.
    logic m_h1, m_h2;
    bit   m_held;
    int   m_run;
    int   m_lp;
    bit   m_en, m_pulse, m_long;

    task automatic model_reset();
        m_h1 = 1'b1; m_h2 = 1'b1;
        m_held = 1'b0; m_run = 0; m_lp = 0;
        m_en = ENR; m_pulse = 1'b0; m_long = 1'b0;
    endtask

    task automatic model_edge(input logic b);
        bit bs;
        bs = ~m_h2;
        m_h2 = m_h1;
        m_h1 = b;
        m_pulse = 1'b0;
        m_long  = 1'b0;
        if (!m_held) begin
            m_run = bs ? m_run + 1 : 0;
            if (m_run == D + 1) begin
                m_held = 1'b1; m_run = 0; m_en = ~m_en; m_pulse = 1'b1;
            end
        end else begin
            if (LP_ON && m_run == 0) begin
                if (m_lp == L - 1) begin
                    m_long = 1'b1; m_en = 1'b0;
                end
                if (m_lp < L) m_lp++;
            end
            m_run = !bs ? m_run + 1 : 0;
            if (m_run == D + 1) begin
                m_held = 1'b0; m_run = 0; m_lp = 0;
            end
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%b want=%b", name, cyc, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0d want=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic step(input logic b);
        btn_n = b;
        @(posedge clk);
        model_edge(b);
        cyc++;
        #1;
        check_bit("enable", enable, m_en);
        check_bit("press_pulse", press_pulse, m_pulse);
        check_bit("long_press", long_press, m_long);
        if (press_pulse === 1'b1) seg_pulses++;
        if (long_press === 1'b1) seg_longs++;
    endtask

    typedef struct {
        logic b;
        int   n;
        logic exp_en;
        logic exp_en_lp;
        int   pulses;
    } seg_t;

    seg_t segs[14];

    initial begin
        #2_000_000;
        $display("FAIL watchdog cycle=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp;
        int   lp_edge;

        // single press, bounce, two clean presses, held press with release glitch
        segs[0]  = '{1'b0, 20, 1'b1, 1'b0, 1};
        segs[1]  = '{1'b1, 10, 1'b1, 1'b0, 0};
        segs[2]  = '{1'b0,  3, 1'b1, 1'b0, 0};
        segs[3]  = '{1'b1,  1, 1'b1, 1'b0, 0};
        segs[4]  = '{1'b0,  3, 1'b1, 1'b0, 0};
        segs[5]  = '{1'b1, 10, 1'b1, 1'b0, 0};
        segs[6]  = '{1'b0, 10, 1'b0, 1'b1, 1};
        segs[7]  = '{1'b1, 10, 1'b0, 1'b1, 0};
        segs[8]  = '{1'b0, 10, 1'b1, 1'b0, 1};
        segs[9]  = '{1'b1, 10, 1'b1, 1'b0, 0};
        segs[10] = '{1'b0, 10, 1'b0, 1'b1, 1};
        segs[11] = '{1'b1,  2, 1'b0, 1'b1, 0};
        segs[12] = '{1'b0,  5, 1'b0, 1'b1, 0};
        segs[13] = '{1'b1, 10, 1'b0, 1'b0, 0};

        rst   = 1'b0;
        btn_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_bit("reset_enable", enable, ENR);
        check_bit("reset_press_pulse", press_pulse, 1'b0);
        check_bit("reset_long_press", long_press, 1'b0);
        rst = 1'b1;
        model_reset();

        for (int i = 0; i < 14; i++) begin
            seg_pulses = 0;
            seg_longs  = 0;
            for (int k = 0; k < segs[i].n; k++) step(segs[i].b);
            exp = LP_ON ? segs[i].exp_en_lp : segs[i].exp_en;
            check_bit($sformatf("seg%0d_enable", i), enable, exp);
            check_int($sformatf("seg%0d_pulses", i), seg_pulses, segs[i].pulses);
        end

        // Async reset in the middle of the debounce of a press.
        repeat (10) step(1'b0);
        repeat (10) step(1'b1);
        check_bit("pre_rst_enable", enable, 1'b1);
        seg_pulses = 0;
        repeat (5) step(1'b0);
        #2;
        rst = 1'b0;
        #1;
        check_bit("async_rst_enable", enable, ENR);
        check_bit("async_rst_press_pulse", press_pulse, 1'b0);
        btn_n = 1'b1;
        @(posedge clk);
        #1;
        check_bit("held_rst_enable", enable, ENR);
        rst = 1'b1;
        model_reset();
        seg_pulses = 0;
        repeat (10) step(1'b1);
        check_int("post_rst_pulses", seg_pulses, 0);
        check_bit("post_rst_enable", enable, ENR);
        repeat (10) step(1'b0);
        repeat (10) step(1'b1);
        check_int("new_press_pulses", seg_pulses, 1);
        check_bit("new_press_enable", enable, ~ENR);

        // Random button activity with irregular run lengths.
        for (int r = 0; r < 40; r++) begin
            logic b;
            int   n;
            b = logic'($urandom_range(0, 1));
            n = $urandom_range(1, 12);
            repeat (n) step(b);
        end
        repeat (12) step(1'b1);

`ifdef LONG_PRESS_EN
        for (int t = 0; t < 2 && !m_en; t++) begin
            repeat (10) step(1'b0);
            repeat (10) step(1'b1);
        end
        check_bit("lp_pre_enable", enable, 1'b1);
        seg_pulses = 0;
        seg_longs  = 0;
        lp_edge    = 0;
        for (int k = 1; k <= 30; k++) begin
            step(1'b0);
            if (long_press === 1'b1) lp_edge = k;
            if (k == 7) check_bit("lp_toggle_edge7", enable, 1'b0);
        end
        check_int("lp_strobes", seg_longs, 1);
        check_int("lp_strobe_edge", lp_edge, 17);
        check_int("lp_press_pulses", seg_pulses, 1);
        check_bit("lp_enable_after", enable, 1'b0);
        repeat (10) step(1'b1);
`else
        lp_edge   = 0;
        seg_longs = 0;
        repeat (30) step(1'b0);
        repeat (10) step(1'b1);
        check_int("no_lp_strobes", seg_longs, lp_edge);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
